// File: rtl/binary_bbox_tracker.sv
// binary_bbox_tracker
// Tracks the bounding box and the population of set pixels in a 1-bit mask
// stream delivered in raster order. At the end of each frame the result is
// latched into held output registers, and o_done pulses for one cycle.
//
// Ports
//   i_clk      clock
//   i_rst      synchronous active-high reset
//   i_valid    pixel strobe; one pixel per high cycle, gaps allowed
//   i_data     mask pixel, 1 = object
//   i_resync   abort current frame; next valid pixel is (0,0)
//   o_done     one-cycle pulse; result registers hold new values this cycle
//   o_found    last frame count >= MIN_COUNT
//   o_x_min / o_x_max / o_y_min / o_y_max   bounds of last frame
//   o_count    set pixels in last frame
//
// State table
//   S_ACCUM  | counting pixels of the current frame
//   S_REPORT | first cycle after a frame end; o_done high, still accumulating
module binary_bbox_tracker #(
  parameter int WIDTH     = 800,
  parameter int HEIGHT    = 600,
  parameter int MIN_COUNT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_data,
  input  logic        i_resync,
  output logic        o_done,
  output logic        o_found,
  output logic [9:0]  o_x_min,
  output logic [9:0]  o_x_max,
  output logic [9:0]  o_y_min,
  output logic [9:0]  o_y_max,
  output logic [18:0] o_count
);

  typedef enum logic {S_ACCUM, S_REPORT} state_t;

  localparam logic [9:0]  LAST_COL = 10'(WIDTH - 1);
  localparam logic [9:0]  LAST_ROW = 10'(HEIGHT - 1);
  localparam logic [9:0]  MIN_INIT = 10'd1023;
  localparam logic [18:0] MIN_CNT  = 19'(MIN_COUNT);

  state_t      r_state;
  logic [9:0]  r_col;
  logic [9:0]  r_row;
  logic [18:0] r_cnt;
  logic [9:0]  r_xmin;
  logic [9:0]  r_xmax;
  logic [9:0]  r_ymin;
  logic [9:0]  r_ymax;

  logic        r_found;
  logic [9:0]  r_x_min_o;
  logic [9:0]  r_x_max_o;
  logic [9:0]  r_y_min_o;
  logic [9:0]  r_y_max_o;
  logic [18:0] r_count_o;

  logic        w_hit;
  logic        w_last_col;
  logic        w_last_row;
  logic        w_frame_end;
  logic [18:0] w_cnt_nx;
  logic [9:0]  w_xmin_nx;
  logic [9:0]  w_xmax_nx;
  logic [9:0]  w_ymin_nx;
  logic [9:0]  w_ymax_nx;
  logic        w_empty;

  assign w_hit       = i_valid & i_data;
  assign w_last_col  = (r_col == LAST_COL);
  assign w_last_row  = (r_row == LAST_ROW);
  // Resync wins over frame end: an aborted last pixel never reports.
  assign w_frame_end = i_valid & w_last_col & w_last_row & ~i_resync;

  // Accumulator values including the pixel presented this cycle, so the
  // frame-end capture sees the final pixel.
  assign w_cnt_nx  = r_cnt + {18'd0, w_hit};
  assign w_xmin_nx = (w_hit && (r_col < r_xmin)) ? r_col : r_xmin;
  assign w_xmax_nx = (w_hit && (r_col > r_xmax)) ? r_col : r_xmax;
  assign w_ymin_nx = (w_hit && (r_row < r_ymin)) ? r_row : r_ymin;
  assign w_ymax_nx = (w_hit && (r_row > r_ymax)) ? r_row : r_ymax;
  assign w_empty   = (w_cnt_nx == 19'd0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_ACCUM;
      r_col     <= '0;
      r_row     <= '0;
      r_cnt     <= '0;
      r_xmin    <= MIN_INIT;
      r_xmax    <= '0;
      r_ymin    <= MIN_INIT;
      r_ymax    <= '0;
      r_found   <= 1'b0;
      r_x_min_o <= '0;
      r_x_max_o <= '0;
      r_y_min_o <= '0;
      r_y_max_o <= '0;
      r_count_o <= '0;
    end else if (i_resync) begin
      r_state <= S_ACCUM;
      r_col   <= '0;
      r_row   <= '0;
      r_cnt   <= '0;
      r_xmin  <= MIN_INIT;
      r_xmax  <= '0;
      r_ymin  <= MIN_INIT;
      r_ymax  <= '0;
    end else begin
      if (i_valid) begin
        if (w_last_col) begin
          r_col <= '0;
          r_row <= w_last_row ? 10'd0 : r_row + 10'd1;
        end else begin
          r_col <= r_col + 10'd1;
        end
      end

      if (w_frame_end) begin
        r_state   <= S_REPORT;
        r_found   <= ~w_empty && (w_cnt_nx >= MIN_CNT);
        // An empty frame reports zero bounds rather than the init sentinels.
        r_x_min_o <= w_empty ? 10'd0 : w_xmin_nx;
        r_x_max_o <= w_empty ? 10'd0 : w_xmax_nx;
        r_y_min_o <= w_empty ? 10'd0 : w_ymin_nx;
        r_y_max_o <= w_empty ? 10'd0 : w_ymax_nx;
        r_count_o <= w_cnt_nx;
        r_cnt     <= '0;
        r_xmin    <= MIN_INIT;
        r_xmax    <= '0;
        r_ymin    <= MIN_INIT;
        r_ymax    <= '0;
      end else begin
        r_state <= S_ACCUM;
        r_cnt   <= w_cnt_nx;
        r_xmin  <= w_xmin_nx;
        r_xmax  <= w_xmax_nx;
        r_ymin  <= w_ymin_nx;
        r_ymax  <= w_ymax_nx;
      end
    end
  end

  assign o_done  = (r_state == S_REPORT);
  assign o_found = r_found;
  assign o_x_min = r_x_min_o;
  assign o_x_max = r_x_max_o;
  assign o_y_min = r_y_min_o;
  assign o_y_max = r_y_max_o;
  assign o_count = r_count_o;

endmodule

// File: tb/tb_binary_bbox_tracker.sv
// Bench for binary_bbox_tracker, run on a reduced 32x24 frame so that many
// whole frames fit in a short run. Each frame is built as a 2-D mask; the
// expected result is computed by scanning that mask.
module tb_binary_bbox_tracker;

  localparam int TW   = 32;
  localparam int TH   = 24;
  localparam int TMIN = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        data = 1'b0;
  logic        resync = 1'b0;
  logic        o_done;
  logic        o_found;
  logic [9:0]  o_x_min, o_x_max, o_y_min, o_y_max;
  logic [18:0] o_count;

  always #5 clk = ~clk;

  binary_bbox_tracker #(.WIDTH(TW), .HEIGHT(TH), .MIN_COUNT(TMIN)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_data(data),
    .i_resync(resync), .o_done(o_done), .o_found(o_found),
    .o_x_min(o_x_min), .o_x_max(o_x_max), .o_y_min(o_y_min),
    .o_y_max(o_y_max), .o_count(o_count)
  );

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int exp_ndone = 0;
  bit mask [TH][TW];
  bit pending = 0;
  int e_found = 0, e_xmin = 0, e_xmax = 0, e_ymin = 0, e_ymax = 0, e_cnt = 0;

  always @(negedge clk) if (o_done) n_done++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, "_found"}, 32'(o_found), 32'(e_found));
    chk({tag, "_xmin"},  32'(o_x_min), 32'(e_xmin));
    chk({tag, "_xmax"},  32'(o_x_max), 32'(e_xmax));
    chk({tag, "_ymin"},  32'(o_y_min), 32'(e_ymin));
    chk({tag, "_ymax"},  32'(o_y_max), 32'(e_ymax));
    chk({tag, "_count"}, 32'(o_count), 32'(e_cnt));
  endtask

  task automatic model_frame();
    int n = 0, x0 = TW, x1 = -1, y0 = TH, y1 = -1;
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        if (mask[r][c]) begin
          n++;
          if (c < x0) x0 = c;
          if (c > x1) x1 = c;
          if (r < y0) y0 = r;
          if (r > y1) y1 = r;
        end
    e_cnt = n;
    if (n == 0) begin
      e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    end else begin
      e_found = (n >= TMIN) ? 1 : 0;
      e_xmin = x0; e_xmax = x1; e_ymin = y0; e_ymax = y1;
    end
  endtask

  // Called at every negedge while driving: checks the cycle right after a
  // frame's last pixel, which is also where the next frame may start.
  task automatic do_pending();
    if (pending) begin
      pending = 0;
      chk("done_lat", 32'(o_done), 32'd1);
      chk_outputs("frame");
    end
  endtask

  task automatic clear_mask();
    for (int r = 0; r < TH; r++)
      for (int c = 0; c < TW; c++)
        mask[r][c] = 1'b0;
  endtask

  task automatic box(input int x0, input int x1, input int y0, input int y1);
    for (int r = y0; r <= y1; r++)
      for (int c = x0; c <= x1; c++)
        mask[r][c] = 1'b1;
  endtask

  // abort_kind: 0 = full frame, 1 = resync (with valid) at abort_row, 2 = reset
  task automatic drive_frame(input int gap_max, input int abort_row, input int abort_kind);
    for (int r = 0; r < TH; r++) begin
      for (int c = 0; c < TW; c++) begin
        if (abort_kind != 0 && r == abort_row && c == 0) begin
          @(negedge clk);
          do_pending();
          data = 1'b1;
          if (abort_kind == 1) begin
            valid = 1'b1; resync = 1'b1;
          end else begin
            valid = 1'b0; rst = 1'b1;
          end
          @(negedge clk);
          valid = 1'b0; resync = 1'b0; rst = 1'b0; data = 1'b0;
          if (abort_kind == 2) begin
            e_found = 0; e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0; e_cnt = 0;
          end
          return;
        end
        repeat ($urandom_range(0, gap_max)) begin
          @(negedge clk);
          do_pending();
          valid = 1'b0;
        end
        @(negedge clk);
        do_pending();
        valid = 1'b1;
        data = mask[r][c];
      end
    end
    model_frame();
    exp_ndone++;
    pending = 1;
  endtask

  task automatic flush();
    @(negedge clk);
    do_pending();
    valid = 1'b0;
    data = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, "_ndone"}, 32'(n_done), 32'(exp_ndone));
    chk({tag, "_done0"}, 32'(o_done), 32'd0);
    chk_outputs(tag);
  endtask

  task automatic random_mask();
    int x0, x1, y0, y1, dens;
    clear_mask();
    x0 = $urandom_range(0, TW - 1); x1 = $urandom_range(x0, TW - 1);
    y0 = $urandom_range(0, TH - 1); y1 = $urandom_range(y0, TH - 1);
    dens = $urandom_range(0, 100);
    for (int r = y0; r <= y1; r++)
      for (int c = x0; c <= x1; c++)
        mask[r][c] = ($urandom_range(1, 100) <= dens);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_done", 32'(o_done), 32'd0);
    chk_outputs("rst");

    clear_mask(); mask[5][12] = 1'b1;
    drive_frame(0, 0, 0); flush(); chk_idle("single");

    clear_mask(); box(10, 19, 8, 15);
    drive_frame(2, 0, 0); flush(); chk_idle("rect");

    clear_mask();
    drive_frame(1, 0, 0); flush(); chk_idle("empty");

    clear_mask(); mask[0][0] = 1'b1; mask[TH-1][TW-1] = 1'b1;
    drive_frame(3, 0, 0); flush(); chk_idle("corners");

    clear_mask(); box(3, 10, 7, 7);
    drive_frame(0, 0, 0); flush(); chk_idle("min_eq");
    clear_mask(); box(3, 9, 7, 7);
    drive_frame(0, 0, 0); flush(); chk_idle("min_below");

    clear_mask(); box(2, 5, 1, 3);
    drive_frame(0, 0, 0);
    clear_mask(); box(20, 25, 10, 12);
    drive_frame(0, 0, 0); flush(); chk_idle("b2b");

    clear_mask(); box(1, 30, 2, 20);
    drive_frame(1, 12, 1); chk_idle("resync");
    clear_mask(); box(4, 6, 20, 22);
    drive_frame(1, 0, 0); flush(); chk_idle("post_resync");

    clear_mask(); box(1, 30, 2, 20);
    drive_frame(1, 12, 2); chk_idle("reset");
    clear_mask(); box(7, 8, 0, 23);
    drive_frame(0, 0, 0); flush(); chk_idle("post_reset");

    for (int k = 0; k < 6; k++) begin
      random_mask();
      drive_frame((k % 2) * 2, 0, 0);
    end
    flush(); chk_idle("random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
